// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stage sequencing controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Holds the 3-bit FSM state encoding, the RUN-state event priority order
// (pick_event), the FLUSH/DRAIN cycle counter width and the stall counter width.
package pipe_ctrl_pkg;

  localparam int CNT_W       = 4;   // FLUSH/DRAIN cycle counter width
  localparam int STALL_CNT_W = 16;  // stall_count width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_WAIT  = 3'd3,
    S_RI    = 3'd4,
    S_FLUSH = 3'd5,
    S_DRAIN = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  // Decoded event in RUN/STALL, one winner per cycle.
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_BRANCH   = 3'd1,
    EV_MEM_WAIT = 3'd2,
    EV_RAW      = 3'd3,
    EV_RI       = 3'd4,
    EV_HALT     = 3'd5
  } ev_t;

  // Fixed priority: branch > mem_wait > raw hazard > Ri fetch > halt.
  // Losers are dropped, not remembered.
  function automatic ev_t pick_event(input logic branch_taken,
                                     input logic mem_wait,
                                     input logic raw_hazard,
                                     input logic ri_fetch,
                                     input logic halt_req);
    ev_t ev;
    if (branch_taken)    ev = EV_BRANCH;
    else if (mem_wait)   ev = EV_MEM_WAIT;
    else if (raw_hazard) ev = EV_RAW;
    else if (ri_fetch)   ev = EV_RI;
    else if (halt_req)   ev = EV_HALT;
    else                 ev = EV_NONE;
    return ev;
  endfunction

endpackage

// File: rtl/pipe_cycle_cnt.sv
// Loadable down-counter with hold and zero flag, shared by FLUSH and DRAIN.
// Latency: load/decrement visible one cycle after the clock edge; zero is combinational from the count.
// Backpressure: hold freezes the count; the count stops at zero instead of wrapping.
//
// Ports: clk, clr (async active-high), load/load_val (reload, wins over hold),
//        hold (freeze), zero (count == 0).
module pipe_cycle_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Sequencer driving load/shift/Ri/bubble strobes of the pipeline stage registers and the PC enable.
// Latency: strobes are combinational from state and inputs (zero cycles from event to strobe).
// Backpressure: mem_wait freezes every stage and the PC; raw_hazard freezes stages 0..HAZ_STAGE.
//
// Ports: clk, clr (async active-high); start, branch_taken, mem_wait, raw_hazard,
//        ri_fetch, halt_req (event inputs); c_left, c_right, ld_ri, bubble (per-stage
//        strobes, bit 0 = stage nearest fetch); pc_en; busy; stall_count.
// Build option: define PIPE_STALL_CNT_EN for a live saturating stall_count,
//        otherwise stall_count is tied to zero and no counter flops exist.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 4,
  parameter int HAZ_STAGE = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   branch_taken,
  input  logic                   mem_wait,
  input  logic                   raw_hazard,
  input  logic                   ri_fetch,
  input  logic                   halt_req,
  output logic [NSTAGE-1:0]      c_left,
  output logic [NSTAGE-1:0]      c_right,
  output logic [NSTAGE-1:0]      ld_ri,
  output logic [NSTAGE-1:0]      bubble,
  output logic                   pc_en,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [NSTAGE-1:0] ALL_STG  = '1;
  localparam logic [NSTAGE-1:0] STG0     = NSTAGE'(1);
  localparam logic [NSTAGE-1:0] STG01    = NSTAGE'(3);
  // Stages 0..HAZ_STAGE hold their contents on a RAW hazard.
  localparam logic [NSTAGE-1:0] HAZ_HOLD = NSTAGE'((1 << (HAZ_STAGE + 1)) - 1);
  localparam logic [NSTAGE-1:0] HAZ_BUB  = NSTAGE'(1 << (HAZ_STAGE + 1));
  // Counter holds "cycles remaining minus one" so the exit happens on the zero edge.
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(NSTAGE - 1);

  state_t state_q, state_d;
  ev_t    ev;
  logic   run_like;
  logic   cnt_load, cnt_hold, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  assign ev = pick_event(branch_taken, mem_wait, raw_hazard, ri_fetch, halt_req);

  // STALL decodes events exactly like RUN: a held hazard keeps STALL, mem_wait
  // takes WAIT, and once the hazard drops the cycle already runs normally.
  assign run_like = (state_q == S_RUN) || (state_q == S_STALL);

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        case (ev)
          EV_BRANCH:   state_d = (FLUSH_CYC > 0) ? S_FLUSH : S_RUN;
          EV_MEM_WAIT: state_d = S_WAIT;
          EV_RAW:      state_d = S_STALL;
          EV_RI:       state_d = S_RI;
          EV_HALT:     state_d = S_DRAIN;
          default:     state_d = S_RUN;
        endcase
      end
      S_WAIT: begin
        if (!mem_wait) state_d = S_RUN;
      end
      S_RI: begin
        state_d = S_RUN;
      end
      S_FLUSH: begin
        if (cnt_zero) state_d = S_RUN;
      end
      S_DRAIN: begin
        if (!mem_wait && cnt_zero) state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- strobe decode ----------------
  always_comb begin
    c_left  = '0;
    c_right = '0;
    ld_ri   = '0;
    bubble  = '0;
    pc_en   = 1'b0;
    case (state_q)
      S_RUN, S_STALL: begin
        c_left  = ALL_STG;
        c_right = ALL_STG;
        pc_en   = 1'b1;
        case (ev)
          // Wrong-path words in stages 0 and 1 are zeroed while the PC loads the target.
          EV_BRANCH: bubble = STG01;
          EV_MEM_WAIT: begin
            c_left  = '0;
            c_right = '0;
            pc_en   = 1'b0;
          end
          EV_RAW: begin
            c_left  = ~HAZ_HOLD;
            c_right = ~HAZ_HOLD;
            bubble  = HAZ_BUB;
            pc_en   = 1'b0;
          end
          default: ;
        endcase
      end
      S_RI: begin
        // Stage 0 keeps its instruction and takes only the immediate word.
        c_left  = ALL_STG & ~STG0;
        c_right = ALL_STG & ~STG0;
        ld_ri   = STG0;
        pc_en   = 1'b1;
      end
      S_FLUSH: begin
        c_left  = ALL_STG;
        c_right = ALL_STG;
        bubble  = STG0;
        pc_en   = 1'b1;
      end
      S_DRAIN: begin
        // A memory wait during drain freezes the pipe as well as the drain count.
        if (!mem_wait) begin
          c_left  = ALL_STG;
          c_right = ALL_STG;
          bubble  = STG0;
        end
      end
      default: ;
    endcase
  end

  assign busy = !((state_q == S_IDLE) || (state_q == S_HALT));

  // ---------------- FLUSH / DRAIN cycle counter ----------------
  assign cnt_load     = run_like && (((ev == EV_BRANCH) && (FLUSH_CYC > 0)) || (ev == EV_HALT));
  assign cnt_load_val = (ev == EV_HALT) ? DRAIN_LOAD : FLUSH_LOAD;
  assign cnt_hold     = !((state_q == S_FLUSH) || ((state_q == S_DRAIN) && !mem_wait));

  pipe_cycle_cnt u_cycle_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .hold     (cnt_hold),
    .zero     (cnt_zero)
  );

  // ---------------- stall counter ----------------
`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_q <= '0;
    end else if (((state_q == S_STALL) || (state_q == S_WAIT)) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl (NSTAGE=4, HAZ_STAGE=1, FLUSH_CYC=1).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Table rows cover one cycle each; halt/drain and async clear are hand-written sequences.
module tb_pipe_stage_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_STALL_CNT_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0, branch_taken = 1'b0, mem_wait = 1'b0;
  logic        raw_hazard = 1'b0, ri_fetch = 1'b0, halt_req = 1'b0;
  logic [3:0]  c_left, c_right, ld_ri, bubble;
  logic        pc_en, busy;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.NSTAGE(4), .HAZ_STAGE(1), .FLUSH_CYC(1)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .branch_taken (branch_taken),
    .mem_wait     (mem_wait),
    .raw_hazard   (raw_hazard),
    .ri_fetch     (ri_fetch),
    .halt_req     (halt_req),
    .c_left       (c_left),
    .c_right      (c_right),
    .ld_ri        (ld_ri),
    .bubble       (bubble),
    .pc_en        (pc_en),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  // Bench-side protocol rule: a taken branch must never arrive while stalled.
  always @(posedge clk) begin
    if (!clr && dut.state_q == S_STALL)
      assert (!branch_taken) else $error("illegal branch_taken while stalled");
  end

  // inputs packed as {clr, start, branch_taken, mem_wait, raw_hazard, ri_fetch, halt_req}
  typedef struct {
    logic [6:0]  in;
    logic [3:0]  cl, cr, ld, bub;
    logic        pc, bz;
    logic [15:0] sc;   // value when the stall counter is built in
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] cl, input logic [3:0] cr,
                         input logic [3:0] ld, input logic [3:0] bub, input logic pc,
                         input logic bz, input logic [15:0] sc);
    chk({tag, ".c_left"},      32'(c_left),      32'(cl));
    chk({tag, ".c_right"},     32'(c_right),     32'(cr));
    chk({tag, ".ld_ri"},       32'(ld_ri),       32'(ld));
    chk({tag, ".bubble"},      32'(bubble),      32'(bub));
    chk({tag, ".pc_en"},       32'(pc_en),       32'(pc));
    chk({tag, ".busy"},        32'(busy),        32'(bz));
    chk({tag, ".stall_count"}, 32'(stall_count), SC_EN ? 32'(sc) : 32'd0);
  endtask

  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {clr, start, branch_taken, mem_wait, raw_hazard, ri_fetch, halt_req} = v;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int drain_cycles;
    bit timed_out;

    //                in          cl     cr     ld     bub    pc    busy  sc
    tbl[0]  = '{7'b1000000, 4'h0,  4'h0,  4'h0,  4'h0,  1'b0, 1'b0, 16'd0}; // in reset
    tbl[1]  = '{7'b1100000, 4'h0,  4'h0,  4'h0,  4'h0,  1'b0, 1'b0, 16'd0}; // start ignored under clr
    tbl[2]  = '{7'b0100000, 4'h0,  4'h0,  4'h0,  4'h0,  1'b0, 1'b0, 16'd0}; // IDLE samples start
    tbl[3]  = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd0}; // first RUN
    tbl[4]  = '{7'b0010100, 4'hF,  4'hF,  4'h0,  4'h3,  1'b1, 1'b1, 16'd0}; // branch beats raw
    tbl[5]  = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h1,  1'b1, 1'b1, 16'd0}; // FLUSH
    tbl[6]  = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd0}; // RUN
    tbl[7]  = '{7'b0000100, 4'hC,  4'hC,  4'h0,  4'h4,  1'b0, 1'b1, 16'd0}; // raw detect
    tbl[8]  = '{7'b0000100, 4'hC,  4'hC,  4'h0,  4'h4,  1'b0, 1'b1, 16'd0}; // STALL
    tbl[9]  = '{7'b0000100, 4'hC,  4'hC,  4'h0,  4'h4,  1'b0, 1'b1, 16'd1}; // STALL
    tbl[10] = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd2}; // hazard gone
    tbl[11] = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd3}; // RUN
    tbl[12] = '{7'b0000011, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd3}; // ri beats halt
    tbl[13] = '{7'b0000000, 4'hE,  4'hE,  4'h1,  4'h0,  1'b1, 1'b1, 16'd3}; // RI
    tbl[14] = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd3}; // RUN, halt not latched
    tbl[15] = '{7'b0001011, 4'h0,  4'h0,  4'h0,  4'h0,  1'b0, 1'b1, 16'd3}; // mem_wait wins, freeze
    tbl[16] = '{7'b0000000, 4'h0,  4'h0,  4'h0,  4'h0,  1'b0, 1'b1, 16'd3}; // WAIT, mem_wait fell
    tbl[17] = '{7'b0000000, 4'hF,  4'hF,  4'h0,  4'h0,  1'b1, 1'b1, 16'd4}; // RUN

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].in);
      chk_all($sformatf("v%0d", i), tbl[i].cl, tbl[i].cr, tbl[i].ld, tbl[i].bub,
              tbl[i].pc, tbl[i].bz, tbl[i].sc);
    end

    // ---- halt with a 2-cycle memory wait inside DRAIN ----
    drive(7'b0000001);
    chk_all("halt_req", 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 16'd4);
    drain_cycles = 0;
    timed_out = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      drive((k == 2 || k == 3) ? 7'b0001000 : 7'b0000000);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      drain_cycles++;
      chk($sformatf("drain%0d.pc_en", k), 32'(pc_en), 32'd0);
      if (k == 2 || k == 3)
        chk($sformatf("drain%0d.frozen_c_left", k), 32'(c_left), 32'h0);
      else
        chk($sformatf("drain%0d.bubble", k), 32'(bubble), 32'h1);
    end
    chk("drain_timeout", 32'(timed_out), 32'd0);
    chk("drain_cycles", 32'(drain_cycles), 32'd6);
    chk_all("halted", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd4);
    drive(7'b0011100);  // events ignored in HALT
    chk_all("halt_ignore", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd4);
    drive(7'b0100000);
    chk_all("halt_start", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd4);
    drive(7'b0000000);
    chk_all("resume", 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 16'd4);

    // ---- asynchronous clear in the middle of a stall ----
    drive(7'b0000100);
    chk_all("stall_a", 4'hC, 4'hC, 4'h0, 4'h4, 1'b0, 1'b1, 16'd4);
    drive(7'b0000100);
    chk_all("stall_b", 4'hC, 4'hC, 4'h0, 4'h4, 1'b0, 1'b1, 16'd4);
    #2;
    clr = 1'b1;
    #1;
    chk_all("async_clr", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd0);
    drive(7'b1000100);
    drive(7'b0000100);  // released with hazard still high: IDLE ignores it
    chk_all("post_clr", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd0);
    drive(7'b0100000);
    chk_all("post_clr_start", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'd0);
    drive(7'b0000000);
    chk_all("post_clr_run", 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Sequencing controller for the processor's chain of pipeline stage registers. Each cycle it generates the per-stage load-left (`c_left`), shift-right (`c_right`), load-Ri (`ld_ri`) and `bubble` strobes, plus the PC enable. It resolves branch flushes, memory waits, read-after-write hazards, second-word (Ri) fetches and halt/drain requests under a fixed priority. It sits beside the stage registers and is the only block that drives their control pins.

## Interface
- `NSTAGE`, 4: number of stage registers controlled; bit i of each vector drives stage register i, stage 0 nearest fetch.
- `HAZ_STAGE`, 1: last stage frozen on a RAW hazard; bubble is injected into stage `HAZ_STAGE+1`. Legal range is 0..`NSTAGE`-2.
- `FLUSH_CYC`, 1: extra cycles stage 0 is bubbled after a taken branch. Legal range is 0..15.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `clr`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: leave IDLE/HALT and begin execution.
- `branch_taken`, in, 1: branch resolved taken this cycle.
- `mem_wait`, in, 1: memory not ready; freeze the whole pipe.
- `raw_hazard`, in, 1: operand dependency detected at stage `HAZ_STAGE`.
- `ri_fetch`, in, 1: instruction in stage 0 needs its immediate word loaded into Ri.
- `halt_req`, in, 1: stop fetching, drain, and halt.
- `c_left`, out, `NSTAGE`: per-stage load-all strobe.
- `c_right`, out, `NSTAGE`: per-stage shift-to-output strobe.
- `ld_ri`, out, `NSTAGE`: per-stage Ri-only load strobe. Only bit 0 is ever driven high.
- `bubble`, out, `NSTAGE`: per-stage bubble (zero) strobe.
- `pc_en`, out, 1: PC advance or load enable.
- `busy`, out, 1: high in every state except IDLE and HALT.
- `stall_count`, out, 16: stall-cycle counter (see Configuration).

## Operation
- States are IDLE, RUN, STALL, WAIT, RI, FLUSH, DRAIN, HALT.
- Reset state is IDLE. While `clr`=1 every output is 0 and the counters are 0.
- IDLE/HALT: all strobes 0, `pc_en`=0. If `start`=1, go to RUN. All other inputs are ignored.
- RUN, no event: `c_left` and `c_right` all 1, `bubble` and `ld_ri` 0, `pc_en`=1.
- Event priority in RUN: `branch_taken` > `mem_wait` > `raw_hazard` > `ri_fetch` > `halt_req`. Lower-priority inputs in the same cycle are ignored. They are not latched and must be re-asserted.
- `branch_taken`:
  - Same cycle: RUN strobes, except `bubble[0]` and `bubble[1]`=1 and `pc_en`=1 (target load).
  - If `FLUSH_CYC`>0, go to FLUSH. Otherwise stay in RUN.
- FLUSH: `bubble[0]`=1 and other stages shift normally. Lasts `FLUSH_CYC` cycles, then RUN.
- `mem_wait`: go to WAIT. In WAIT all strobes are 0 and `pc_en`=0. Return to RUN the cycle after `mem_wait` falls.
- `raw_hazard`: go to STALL.
  - Stages 0..`HAZ_STAGE`: `c_left`=`c_right`=0.
  - Stage `HAZ_STAGE+1`: `bubble`=1.
  - Stages above it shift normally. `pc_en`=0.
  - The same outputs apply combinationally in the detecting cycle.
  - Stay while `raw_hazard`=1. `mem_wait` in STALL takes WAIT. `branch_taken` in STALL is illegal; this is a bench assertion.
- `ri_fetch`: go to RI for exactly one cycle with `ld_ri[0]`=1, `c_left[0]`=`c_right[0]`=0, other stages shift, and `pc_en`=1. Then RUN.
- `halt_req`: go to DRAIN with `pc_en`=0 and `bubble[0]`=1 while the rest shift. After `NSTAGE` cycles go to HALT. `mem_wait` during DRAIN freezes the drain counter.
- The stall counter increments in every STALL or WAIT cycle and saturates at 16'hFFFF.

## Timing
- Outputs are combinational from the current state and inputs. They are consumed by the stage registers at the next rising edge, so there is zero-cycle latency from event to strobe.
- Asserting `clr` mid-operation forces outputs to 0 immediately, with no waiting for an edge. The first RUN cycle is the cycle after `start` is sampled.
- Counter wrap: FLUSH and DRAIN reload their counter on entry. A terminal count of 0 exits on the same edge.
- `NSTAGE`=4, halt: DRAIN lasts exactly 4 cycles and `busy` falls on the 5th edge.

## Configuration
- `PIPE_STALL_CNT_EN` defined: `stall_count` is a live 16-bit saturating counter, cleared only by `clr`.
- `PIPE_STALL_CNT_EN` not defined: no counter flops; `stall_count` is tied to 16'h0000.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state encoding constants (3-bit);
  - the event priority order;
  - the counter width (4) and the `stall_count` width (16).
- Sub-module `pipe_cycle_cnt`: a loadable 4-bit down-counter with a hold input and a zero flag. It is shared by FLUSH and DRAIN. The FSM and strobe decode stay in the top module.

## Test plan
- Reset, then `start` pulse: outputs 0 during `clr`; the next cycle `c_left`=`c_right`=4'b1111, `pc_en`=1, `busy`=1.
- `branch_taken` and `raw_hazard` together, `FLUSH_CYC`=1: `bubble`=4'b0011 and `pc_en`=1; the next cycle `bubble`=4'b0001; then RUN.
- `raw_hazard` for 3 cycles, `HAZ_STAGE`=1: `c_left`=4'b1100 and `bubble`=4'b0100 for 3 cycles; `stall_count`=3 with `PIPE_STALL_CNT_EN`, 0 without.
- `ri_fetch` single cycle: `ld_ri`=4'b0001, `c_left`=4'b1110, `pc_en`=1; back to 4'b1111 the next cycle.
- `halt_req` with a 2-cycle `mem_wait` inside DRAIN: DRAIN spans 6 cycles; `busy`=0 afterwards; `start` resumes RUN.
- `clr` raised asynchronously mid-STALL: all outputs 0 before the next edge; state IDLE after release.
